// File: rtl/instr_byte_queue_pkg.sv
// Shared constants for the fetch -> decode byte queue: byte width, default geometry, clog2.
package instr_byte_queue_pkg;

    localparam int BYTE_W           = 8;
    localparam int DEF_DEPTH        = 16;
    localparam int DEF_PUSH_BYTES   = 4;
    localparam int DEF_WINDOW_BYTES = 5;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/instr_byte_queue_if.sv
// Fetch/decode-facing bus of the instruction byte queue; master = fetch+decode, slave = queue.
interface instr_byte_queue_if
    import instr_byte_queue_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PUSH_BYTES   = DEF_PUSH_BYTES,
    parameter int WINDOW_BYTES = DEF_WINDOW_BYTES,
    parameter int CW           = clog2(DEPTH + 1),
    parameter int LW           = clog2(WINDOW_BYTES + 1)
);
    logic                             flush;
    logic                             push_valid;
    logic [PUSH_BYTES*BYTE_W-1:0]     push_data;
    logic                             push_ready;
    logic [WINDOW_BYTES*BYTE_W-1:0]   win_data;
    logic [LW-1:0]                    win_count;
    logic [LW-1:0]                    pop_len;
    logic [CW-1:0]                    count;

    modport master (
        output flush, push_valid, push_data, pop_len,
        input  push_ready, win_data, win_count, count
    );

    modport slave (
        input  flush, push_valid, push_data, pop_len,
        output push_ready, win_data, win_count, count
    );
endinterface

// File: rtl/instr_byte_ram.sv
// DEPTH x 8 byte store: one PUSH_BYTES-wide wrapping write, one WINDOW_BYTES-wide wrapping async read.
module instr_byte_ram
    import instr_byte_queue_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PUSH_BYTES   = DEF_PUSH_BYTES,
    parameter int WINDOW_BYTES = DEF_WINDOW_BYTES,
    parameter int AW           = clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [AW-1:0]                  waddr,
    input  logic [PUSH_BYTES*BYTE_W-1:0]   wdata,
    input  logic [AW-1:0]                  raddr,
    output logic [WINDOW_BYTES*BYTE_W-1:0] rdata
);
    logic [DEPTH-1:0][BYTE_W-1:0] mem;

    // DEPTH is a power of two, so AW-bit address arithmetic wraps for free.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < PUSH_BYTES; i++)
                mem[waddr + AW'(i)] <= wdata[(PUSH_BYTES-i)*BYTE_W-1 -: BYTE_W];
        end
    end

    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_rd
        assign rdata[(WINDOW_BYTES-i)*BYTE_W-1 -: BYTE_W] = mem[raddr + AW'(i)];
    end

endmodule

// File: rtl/instr_byte_queue.sv
// Circular instruction byte queue between fetch and decode; optional sticky error flag
// enabled with INSTR_QUEUE_ERR_EN.
module instr_byte_queue
    import instr_byte_queue_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int PUSH_BYTES   = DEF_PUSH_BYTES,
    parameter int WINDOW_BYTES = DEF_WINDOW_BYTES
) (
    input  logic              clk,
    input  logic              rst,
`ifdef INSTR_QUEUE_ERR_EN
    input  logic              err_clr,
    output logic              err,
`endif
    instr_byte_queue_if.slave q
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);
    localparam int LW = clog2(WINDOW_BYTES + 1);

    logic [AW-1:0]                  head;
    logic [AW-1:0]                  tail;
    logic [CW-1:0]                  cnt;
    logic [LW-1:0]                  win_cnt;
    logic                           push_fire;
    logic                           pop_ok;
    logic [WINDOW_BYTES*BYTE_W-1:0] raw;

    // Only a full fetch word is accepted; a same-cycle pop is not credited.
    assign q.push_ready = (cnt <= CW'(DEPTH - PUSH_BYTES));
    assign win_cnt      = (cnt >= CW'(WINDOW_BYTES)) ? LW'(WINDOW_BYTES) : LW'(cnt);
    assign q.win_count  = win_cnt;
    assign q.count      = cnt;
    assign push_fire    = q.push_valid && q.push_ready && !q.flush && !rst;
    assign pop_ok       = (q.pop_len <= win_cnt);

    always_ff @(posedge clk) begin
        if (rst || q.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push_fire) tail <= tail + AW'(PUSH_BYTES);
            if (pop_ok)    head <= head + AW'(q.pop_len);
            cnt <= cnt + (push_fire ? CW'(PUSH_BYTES) : '0) - (pop_ok ? CW'(q.pop_len) : '0);
        end
    end

    instr_byte_ram #(
        .DEPTH       (DEPTH),
        .PUSH_BYTES  (PUSH_BYTES),
        .WINDOW_BYTES(WINDOW_BYTES),
        .AW          (AW)
    ) u_ram (
        .clk  (clk),
        .we   (push_fire),
        .waddr(tail),
        .wdata(q.push_data),
        .raddr(head),
        .rdata(raw)
    );

    // Bytes past the valid count are forced to zero so stale storage never leaks to decode.
    for (genvar i = 0; i < WINDOW_BYTES; i++) begin : g_win
        assign q.win_data[(WINDOW_BYTES-i)*BYTE_W-1 -: BYTE_W] =
            (LW'(i) < win_cnt) ? raw[(WINDOW_BYTES-i)*BYTE_W-1 -: BYTE_W] : '0;
    end

`ifdef INSTR_QUEUE_ERR_EN
    logic err_set;
    assign err_set = !pop_ok || (q.push_valid && !q.push_ready && !q.flush);

    always_ff @(posedge clk) begin
        if (rst || q.flush) err <= 1'b0;
        else if (err_set)   err <= 1'b1;
        else if (err_clr)   err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_instr_byte_queue.sv
// Bench for instr_byte_queue: directed vector table, then model-driven wrap and random phases.
module tb_instr_byte_queue;
    import instr_byte_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef INSTR_QUEUE_ERR_EN
    logic err_clr;
    logic err;
`endif

    instr_byte_queue_if bus();

    instr_byte_queue dut (
        .clk    (clk),
        .rst    (rst),
`ifdef INSTR_QUEUE_ERR_EN
        .err_clr(err_clr),
        .err    (err),
`endif
        .q      (bus)
    );

    typedef struct {
        string      tag;
        bit         r;
        bit         fl;
        bit         pv;
        logic [31:0] pd;
        logic [2:0]  pl;
        logic [4:0]  ec;
        logic [2:0]  ewc;
        logic [39:0] ewd;
        bit         erdy;
    } vec_t;

    typedef struct {
        string      tag;
        logic [4:0]  c;
        logic [2:0]  wc;
        logic [39:0] wd;
        bit         rdy;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[$];
    byte unsigned mq[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a plain byte FIFO; returns the outputs expected after this cycle's edge.
    function automatic exp_t model_step(input string tag, input bit r, input bit fl, input bit pv,
                                        input logic [31:0] pd, input logic [2:0] pl);
        exp_t e;
        int   wc;
        bit   rdy;
        wc  = (mq.size() > 5) ? 5 : mq.size();
        rdy = (16 - mq.size()) >= 4;
        if (r || fl) mq.delete();
        else begin
            if (int'(pl) <= wc)
                for (int k = 0; k < int'(pl); k++) void'(mq.pop_front());
            if (pv && rdy)
                for (int k = 3; k >= 0; k--) mq.push_back(pd[k*8 +: 8]);
        end
        e.tag = tag;
        e.c   = 5'(mq.size());
        e.wc  = 3'((mq.size() > 5) ? 5 : mq.size());
        e.wd  = '0;
        for (int k = 0; k < 5; k++)
            e.wd = {e.wd[31:0], (k < mq.size()) ? mq[k] : 8'h00};
        e.rdy = (16 - mq.size()) >= 4;
        return e;
    endfunction

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".count"},      64'(bus.count),      64'(e.c));
        chk({e.tag, ".win_count"},  64'(bus.win_count),  64'(e.wc));
        chk({e.tag, ".win_data"},   64'(bus.win_data),   64'(e.wd));
        chk({e.tag, ".push_ready"}, 64'(bus.push_ready), 64'(e.rdy));
    endtask

    task automatic drive_cycle(input bit r, input bit fl, input bit pv,
                               input logic [31:0] pd, input logic [2:0] pl);
        rst            = r;
        bus.flush      = fl;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_len    = pl;
        @(posedge clk);
        @(negedge clk);
        check_out();
    endtask

    task automatic add(input string tag, input bit r, input bit fl, input bit pv, input logic [31:0] pd,
                       input logic [2:0] pl, input logic [4:0] ec, input logic [2:0] ewc,
                       input logic [39:0] ewd, input bit erdy);
        tbl.push_back('{tag, r, fl, pv, pd, pl, ec, ewc, ewd, erdy});
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.push_valid = 1'b0; bus.push_data = '0; bus.pop_len = '0;
`ifdef INSTR_QUEUE_ERR_EN
        err_clr = 1'b0;
`endif
        //   tag          rst fl pv data          pl cnt wc win_data        rdy
        add("reset",      1, 0, 0, 32'h0,        0, 0,  0, 40'h0,          1);
        add("reset_hold", 1, 0, 1, 32'hDEADBEEF, 0, 0,  0, 40'h0,          1);
        add("push1",      0, 0, 1, 32'hAABBCCDD, 0, 4,  4, 40'hAABBCCDD00, 1);
        add("drain",      0, 0, 0, 32'h0,        4, 0,  0, 40'h0,          1);
        add("push2a",     0, 0, 1, 32'h11223344, 0, 4,  4, 40'h1122334400, 1);
        add("push2b",     0, 0, 1, 32'h55667788, 0, 8,  5, 40'h1122334455, 1);
        add("pop5",       0, 0, 0, 32'h0,        5, 3,  3, 40'h6677880000, 1);
        add("pop2",       0, 0, 0, 32'h0,        2, 1,  1, 40'h8800000000, 1);
        add("fill1",      0, 0, 1, 32'hDEADBEEF, 0, 5,  5, 40'h88DEADBEEF, 1);
        add("fill2",      0, 0, 1, 32'h01020304, 0, 9,  5, 40'h88DEADBEEF, 1);
        add("fill3",      0, 0, 1, 32'h05060708, 0, 13, 5, 40'h88DEADBEEF, 0);
        add("full_push",  0, 0, 1, 32'hA0A1A2A3, 0, 13, 5, 40'h88DEADBEEF, 0);
        add("pop1",       0, 0, 0, 32'h0,        1, 12, 5, 40'hDEADBEEF01, 1);
        add("pop4",       0, 0, 0, 32'h0,        4, 8,  5, 40'h0102030405, 1);
        add("push_pop5",  0, 0, 1, 32'h0A0B0C0D, 5, 7,  5, 40'h0607080A0B, 1);
        add("pop2b",      0, 0, 0, 32'h0,        2, 5,  5, 40'h080A0B0C0D, 1);
        add("push9",      0, 0, 1, 32'h21222324, 0, 9,  5, 40'h080A0B0C0D, 1);
        add("flush",      0, 1, 1, 32'hF0F1F2F3, 2, 0,  0, 40'h0,          1);
        add("post_flush", 0, 0, 1, 32'h31323334, 0, 4,  4, 40'h3132333400, 1);
        add("bad_pop5",   0, 0, 0, 32'h0,        5, 4,  4, 40'h3132333400, 1);
        add("bad_pop7",   0, 0, 0, 32'h0,        7, 4,  4, 40'h3132333400, 1);
        add("push_more",  0, 0, 1, 32'h41424344, 0, 8,  5, 40'h3132333441, 1);
        add("mid_rst",    1, 0, 1, 32'h51525354, 2, 0,  0, 40'h0,          1);
        add("after_rst",  0, 0, 1, 32'h61626364, 0, 4,  4, 40'h6162636400, 1);

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            void'(model_step(v.tag, v.r, v.fl, v.pv, v.pd, v.pl));
            sb.push_back('{v.tag, v.ec, v.ewc, v.ewd, v.erdy});
            drive_cycle(v.r, v.fl, v.pv, v.pd, v.pl);
        end

        // Steady push-4 / pop-3 so head and tail lap the storage several times.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            d = $urandom;
            sb.push_back(model_step("wrap", 0, 0, 1, d, 3));
            drive_cycle(0, 0, 1, d, 3);
        end

        for (int i = 0; i < 120; i++) begin
            logic [31:0] d;
            logic [2:0]  pl;
            bit          pv, fl, r;
            d  = $urandom;
            pl = 3'($urandom_range(0, 7));
            pv = bit'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 31) == 0);
            sb.push_back(model_step("rand", r, fl, pv, d, pl));
            drive_cycle(r, fl, pv, d, pl);
        end

`ifdef INSTR_QUEUE_ERR_EN
        sb.push_back(model_step("e_rst", 1, 0, 0, 32'h0, 0));
        drive_cycle(1, 0, 0, 32'h0, 0);
        chk("err_after_rst", 64'(err), 64'(0));
        sb.push_back(model_step("e_push", 0, 0, 1, 32'hC0C1C2C3, 0));
        drive_cycle(0, 0, 1, 32'hC0C1C2C3, 0);
        sb.push_back(model_step("e_pop2", 0, 0, 0, 32'h0, 2));
        drive_cycle(0, 0, 0, 32'h0, 2);
        chk("err_clean", 64'(err), 64'(0));
        sb.push_back(model_step("e_bad", 0, 0, 0, 32'h0, 3));
        drive_cycle(0, 0, 0, 32'h0, 3);
        chk("err_set", 64'(err), 64'(1));
        sb.push_back(model_step("e_hold", 0, 0, 0, 32'h0, 0));
        drive_cycle(0, 0, 0, 32'h0, 0);
        chk("err_sticky", 64'(err), 64'(1));
        err_clr = 1'b1;
        sb.push_back(model_step("e_clr", 0, 0, 0, 32'h0, 0));
        drive_cycle(0, 0, 0, 32'h0, 0);
        err_clr = 1'b0;
        chk("err_cleared", 64'(err), 64'(0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_byte_queue.md
Name: instr_byte_queue

Overview:
- Parametrised successor to the fixed 40-bit instruction register.
- Buffers fetched instruction bytes in a circular byte queue.
- Accepts PUSH_BYTES-wide fetch words and exposes a WINDOW_BYTES-wide head window to the decoder.
- Decoder consumes a variable number of bytes (0..WINDOW_BYTES) per cycle; sits between fetch and decode.

Parameters:
- DEPTH, 16, storage capacity in bytes; power of 2; DEPTH >= PUSH_BYTES + WINDOW_BYTES.
- PUSH_BYTES, 4, bytes per fetch push.
- WINDOW_BYTES, 5, bytes visible at head (default 40-bit window).
- Derived CW = clog2(DEPTH+1) and LW = clog2(WINDOW_BYTES+1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all contents (redirect).
- push_valid  in  1  fetch word present.
- push_data  in  PUSH_BYTES*8  fetch word; MSB byte is the oldest (first in program order).
- push_ready  out  1  queue can accept a full fetch word this cycle.
- win_data  out  WINDOW_BYTES*8  head window; MSB byte = head byte.
- win_count  out  LW  valid bytes in window = min(count, WINDOW_BYTES).
- pop_len  in  LW  bytes consumed this cycle (0 = none).
- count  out  CW  current occupancy in bytes.

Behaviour:
- Reset: clk is the single clock; rst is synchronous, active-high. On rst: head=0, tail=0, count=0, push_ready=1, win_count=0, win_data=0. Storage contents are don't-care.
- push_ready = (DEPTH - count) >= PUSH_BYTES. It is a function of registered count only and does not credit a same-cycle pop.
- Push fires when push_valid && push_ready. Bytes are written at tail..tail+PUSH_BYTES-1 (mod DEPTH), oldest byte first, and tail advances by PUSH_BYTES.
- push_valid with push_ready=0 is ignored; the fetch stage holds the data.
- Pop is legal when pop_len <= win_count. A legal pop advances head by pop_len (mod DEPTH).
- An illegal pop (pop_len > win_count) is ignored entirely: head and count are unchanged.
- Simultaneous push and legal pop: count_next = count + PUSH_BYTES - pop_len, updated in a single cycle.
- win_data is combinational from storage (zero latency). Byte i of the window is mem[(head+i) mod DEPTH] at bits [(WINDOW_BYTES-i)*8-1 -: 8] for i < win_count. Bytes at i >= win_count read as 0x00.
- Bytes pushed in cycle N are visible in win_data in cycle N+1.
- Wrap-around: pointers wrap modulo DEPTH. Both a push and a window that straddle index DEPTH-1 -> 0 behave identically to the unwrapped case.
- Full: count > DEPTH-PUSH_BYTES forces push_ready=0 even if some bytes are free.
- Empty: win_count=0 and win_data=0. pop_len=0 is always legal.
- flush: next cycle head=tail=0, count=0. flush overrides push and pop in the same cycle. Nothing from that cycle is retained.
- Priority: rst > flush > (push, pop).
- rst mid-operation discards all contents; push_ready=1 on the following cycle.

Optional Feature:
- Macro: INSTR_QUEUE_ERR_EN.
- When defined, adds port err (out, 1) and input err_clr (in, 1).
- err is a sticky flag, set the cycle after either event:
  - an illegal pop (pop_len > win_count);
  - push_valid && !push_ready while flush=0.
- err is cleared by rst, flush or err_clr; a set event in the same cycle as err_clr wins.
- When not defined: the ports are absent and illegal requests are silently ignored as described above.

Decomposition:
- Shared include/package holds:
  - the byte-width constant (8);
  - the clog2 function;
  - default DEPTH/PUSH_BYTES/WINDOW_BYTES values, shared with fetch and decode.
- Natural sub-module: instr_byte_ram. It is a DEPTH x 8 array with one PUSH_BYTES-wide wrapping write port and one WINDOW_BYTES-wide wrapping combinational read port.
- Pointer and count logic stays in instr_byte_queue.

Test Plan:
- Reset with defaults, then push 0xAABBCCDD -> next cycle count=4, win_count=4, win_data=0xAABBCCDD00.
- Push 0x11223344 then 0x55667788, then pop_len=5 -> before pop win_data=0x1122334455; after pop count=3, win_data=0x6677880000.
- Fill to count=13, then push_valid=1 -> push_ready=0, push ignored, count stays 13. Pop 1 -> push_ready=1 next cycle.
- Cycle pushes of 4 and pops of 3 for 40 cycles so pointers wrap; compare window bytes against a reference model every cycle. Also drive simultaneous push and pop_len=5 on a cycle with count=8 -> count_next=7.
- count=9 with push_valid=1, pop_len=2 and flush=1 in the same cycle -> next cycle count=0, win_count=0, push_ready=1.
- With INSTR_QUEUE_ERR_EN: pop_len=3 with win_count=2 -> count unchanged, err=1 next cycle. Hold until err_clr=1 -> err=0 next cycle.
